alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
- Issue/writeback stage wrapped around the 16-bit registered ALU.
- Accepts decoded ALU instructions over a valid/ready handshake and reads operands from an internal 16x16 register file.
- Registers a/b/op into the ALU, then writes the ALU result back to the destination register two edges after issue.
- Resolves read-after-write hazards with a one-cycle stall or a forward from alu_result.

Parameters:
- WIDTH, 16, data width; must equal the ALU width.
- NREGS, 16, register count; index width is log2(NREGS) = 4.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  instruction offered.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_op  in  4  ALU opcode, passed through unchanged.
- in_rd  in  4  destination register.
- in_rs  in  4  source A register.
- in_rt  in  4  source B register; ignored when in_use_imm=1.
- in_imm  in  16  immediate for B.
- in_use_imm  in  1  B := in_imm instead of R[in_rt].
- alu_a  out  16  registered operand A to the ALU.
- alu_b  out  16  registered operand B to the ALU.
- alu_op  out  4  registered opcode to the ALU.
- alu_result  in  16  ALU registered result.
- wb_valid  out  1  writeback occurs at the next edge.
- wb_rd  out  4  writeback destination.
- wb_data  out  16  writeback data; equals alu_result.
- dbg_addr  in  4  debug read index.
- dbg_data  out  16  combinational R[dbg_addr]; register 0 reads 0.

Behaviour:
- Accept happens at an edge where in_valid && in_ready.
- Pipeline state:
  - E1 stage (e1_valid, e1_rd): instruction whose operands sit in alu_a/b/op.
  - E2 stage (e2_valid, e2_rd): instruction whose result sits in alu_result.
- Timing for an accept at edge N:
  - Edge N: alu_a/b/op loaded, e1_valid=1.
  - Edge N+1: ALU latches its result; e2 := e1, so wb_valid=1 during the following cycle.
  - Edge N+2: R[e2_rd] := alu_result when e2_valid.
  - If no accept at an edge, e1_valid := 0 and alu_a/b/op hold their values.
- Operand source priority (evaluated for each of rs and rt):
  - Index 0 → 0. Register 0 reads as zero and writes to it are discarded (wb_valid still asserts).
  - Else index == e2_rd && e2_valid → forward alu_result.
  - Else → R[index].
- Hazard and stall:
  - Hazard = e1_valid && e1_rd != 0 && ((in_rs == e1_rd) || (!in_use_imm && in_rt == e1_rd)).
  - in_ready = !hazard. It is combinational in the in_* fields and is not gated by in_valid.
  - A dependent instruction immediately behind its producer therefore stalls exactly one cycle.
  - At distance 2 the operand comes from the forward path; at distance 3 or more it comes from the register file.
- Same-cycle writeback and read of the same register: the forward path supplies the new value. No write-before-read ordering is relied on.
- Operand width rules: immediate and register values are used at full width; no extension or truncation.
- Reset (rst_n=0 at an edge):
  - All registers := 0; e1_valid := 0, e2_valid := 0.
  - alu_a := 0, alu_b := 0, alu_op := 4'hF (pass-through).
  - wb_valid=0; in_ready=1 from the first cycle after reset.
- Reset mid-operation: in-flight instructions in E1/E2 are dropped and no writeback occurs for them.

Decomposition:
- Shared package comp16_pkg:
  - Opcode constants: ALU_ADD=0, ALU_SUB=1, ALU_MUL=2, ALU_NOT=3, ALU_OR=4, ALU_AND=5, ALU_LNOT=6, ALU_LAND=7, ALU_SHR=8, ALU_SHL=9, ALU_EQ=10, ALU_GT=11, ALU_GE=12, ALU_LOR=13, ALU_XOR=14, ALU_PASS=15.
  - WIDTH and the register-index width constant.
- Sub-module comp16_regfile:
  - 3 combinational read ports (rs, rt, dbg) and 1 synchronous write port.
  - Synchronous active-low clear; register 0 hardwired to zero.
- Hazard detection, forwarding and the E1/E2 valid/tag pipeline stay in alu_operand_stage.

Test Plan:
- Reset: hold rst_n=0 for 2 edges → dbg_data=0 for indices 0..15, in_ready=1, wb_valid=0, alu_op=4'hF.
- Latency:
  - Stimulus: ADD rd=1, rs=0, imm=0x0005, use_imm=1, accepted at edge N.
  - Response: alu_a=0 and alu_b=5 after N; wb_valid=1 with wb_data=5 after N+1; dbg R1=5 after N+2.
- Distance-1 stall:
  - Stimulus: R1=5, then ADD rd=2, rs=1, rt=1 offered the next cycle.
  - Response: in_ready=0 for exactly 1 cycle, then accepted; R2=0x000A.
- Distance-2 forward:
  - Stimulus: load R1=5; independent ADD rd=4, imm=7; then SUB rd=3, rs=1, imm=2.
  - Response: no stall; alu_a=5 taken from alu_result; R3=3, R4=7.
- Register 0:
  - Stimulus: ADD rd=0, imm=0x1234; then OR rd=5, rs=0, imm=0x00F0 issued back-to-back.
  - Response: R0 reads 0, no stall, R5=0x00F0.
- Reset mid-operation:
  - Stimulus: issue two writes (R6=9, R7=3) on consecutive edges, then rst_n=0 for one edge while E1 and E2 are valid.
  - Response: no further wb_valid; R6=R7=0.

Source files
------------

// File: rtl/comp16_pkg.sv
// Shared constants for the 16-bit ALU datapath: data width, register-file
// geometry and the ALU opcode map.
package comp16_pkg;

    localparam int WIDTH     = 16;
    localparam int NREGS     = 16;
    localparam int REG_IDX_W = $clog2(NREGS);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_MUL  = 4'd2;
    localparam logic [3:0] ALU_NOT  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_AND  = 4'd5;
    localparam logic [3:0] ALU_LNOT = 4'd6;
    localparam logic [3:0] ALU_LAND = 4'd7;
    localparam logic [3:0] ALU_SHR  = 4'd8;
    localparam logic [3:0] ALU_SHL  = 4'd9;
    localparam logic [3:0] ALU_EQ   = 4'd10;
    localparam logic [3:0] ALU_GT   = 4'd11;
    localparam logic [3:0] ALU_GE   = 4'd12;
    localparam logic [3:0] ALU_LOR  = 4'd13;
    localparam logic [3:0] ALU_XOR  = 4'd14;
    localparam logic [3:0] ALU_PASS = 4'd15;

endpackage

// File: rtl/comp16_regfile.sv
// Register file: three combinational read ports (rs, rt, debug) and one
// synchronous write port. Register 0 always reads as zero and ignores writes.
module comp16_regfile #(
    parameter int WIDTH = comp16_pkg::WIDTH,
    parameter int NREGS = comp16_pkg::NREGS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_we,
    input  logic [$clog2(NREGS)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(NREGS)-1:0] i_rs_addr,
    output logic [WIDTH-1:0]         o_rs_data,
    input  logic [$clog2(NREGS)-1:0] i_rt_addr,
    output logic [WIDTH-1:0]         o_rt_data,
    input  logic [$clog2(NREGS)-1:0] i_dbg_addr,
    output logic [WIDTH-1:0]         o_dbg_data
);

    logic [WIDTH-1:0] r_regs [NREGS];

    // Clear all entries on reset, otherwise commit the writeback.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: this array is reset on purpose: software expects every
            // register to read zero after reset, so it must be flops, not RAM.
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Index 0 is forced to zero on every read port.
    assign o_rs_data  = (i_rs_addr  == '0) ? '0 : r_regs[i_rs_addr];
    assign o_rt_data  = (i_rt_addr  == '0) ? '0 : r_regs[i_rt_addr];
    assign o_dbg_data = (i_dbg_addr == '0) ? '0 : r_regs[i_dbg_addr];

endmodule

// File: rtl/alu_operand_stage.sv
// Issue/writeback stage around the registered 16-bit ALU. Reads operands,
// registers them into the ALU, tracks the two-deep E1/E2 tag pipeline and
// writes alu_result back two edges after issue. A dependent instruction
// right behind its producer stalls one cycle; at distance two the operand is
// forwarded from alu_result.
module alu_operand_stage #(
    parameter int WIDTH = comp16_pkg::WIDTH,
    parameter int NREGS = comp16_pkg::NREGS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_op,
    input  logic [$clog2(NREGS)-1:0] in_rd,
    input  logic [$clog2(NREGS)-1:0] in_rs,
    input  logic [$clog2(NREGS)-1:0] in_rt,
    input  logic [WIDTH-1:0]         in_imm,
    input  logic                     in_use_imm,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [3:0]               alu_op,
    input  logic [WIDTH-1:0]         alu_result,
    output logic                     wb_valid,
    output logic [$clog2(NREGS)-1:0] wb_rd,
    output logic [WIDTH-1:0]         wb_data,
    input  logic [$clog2(NREGS)-1:0] dbg_addr,
    output logic [WIDTH-1:0]         dbg_data
);

    import comp16_pkg::*;

    localparam int IDX_W = $clog2(NREGS);

    // E1: operands sit in alu_a/b/op. E2: result sits in alu_result.
    logic             r_e1_valid;
    logic [IDX_W-1:0] r_e1_rd;
    logic             r_e2_valid;
    logic [IDX_W-1:0] r_e2_rd;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [3:0]       r_alu_op;

    logic [WIDTH-1:0] w_rs_rf;
    logic [WIDTH-1:0] w_rt_rf;
    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_op_b;
    logic             w_hazard;
    logic             w_accept;

    comp16_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_we       (r_e2_valid),
        .i_waddr    (r_e2_rd),
        .i_wdata    (alu_result),
        .i_rs_addr  (in_rs),
        .o_rs_data  (w_rs_rf),
        .i_rt_addr  (in_rt),
        .o_rt_data  (w_rt_rf),
        .i_dbg_addr (dbg_addr),
        .o_dbg_data (dbg_data)
    );

    // Source priority: index 0 reads zero, then the E2 forward, then the file.
    // The forward also covers a read of the register being written this edge.
    function automatic logic [WIDTH-1:0] pick_operand(
        input logic [IDX_W-1:0] idx,
        input logic [WIDTH-1:0] rf_val,
        input logic             e2_valid,
        input logic [IDX_W-1:0] e2_rd,
        input logic [WIDTH-1:0] fwd_val
    );
        if (idx == '0) begin
            return '0;
        end else if (e2_valid && (idx == e2_rd)) begin
            return fwd_val;
        end
        return rf_val;
    endfunction

    // Operand selection and hazard detection against the E1 producer.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        w_op_a   = '0;
        w_op_b   = '0;
        w_hazard = 1'b0;

        w_op_a = pick_operand(in_rs, w_rs_rf, r_e2_valid, r_e2_rd, alu_result);
        if (in_use_imm) begin
            w_op_b = in_imm;
        end else begin
            w_op_b = pick_operand(in_rt, w_rt_rf, r_e2_valid, r_e2_rd, alu_result);
        end

        // The E1 result is not visible anywhere yet, so its consumers wait.
        if (r_e1_valid && (r_e1_rd != '0)) begin
            w_hazard = (in_rs == r_e1_rd) || (!in_use_imm && (in_rt == r_e1_rd));
        end
    end

    assign in_ready = !w_hazard;
    assign w_accept = in_valid && in_ready;

    // Advance the E1/E2 tags and load the ALU operand registers on accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            r_e1_valid <= 1'b0;
            r_e1_rd    <= '0;
            r_e2_valid <= 1'b0;
            r_e2_rd    <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= ALU_PASS;
        end else begin
            r_e2_valid <= r_e1_valid;
            r_e2_rd    <= r_e1_rd;
            r_e1_valid <= w_accept;
            if (w_accept) begin
                r_e1_rd  <= in_rd;
                r_alu_a  <= w_op_a;
                r_alu_b  <= w_op_b;
                r_alu_op <= in_op;
            end
        end
    end

    assign alu_a    = r_alu_a;
    assign alu_b    = r_alu_b;
    assign alu_op   = r_alu_op;
    assign wb_valid = r_e2_valid;
    assign wb_rd    = r_e2_rd;
    assign wb_data  = alu_result;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: a behavioural registered ALU closes the loop,
// a vector table drives back-to-back instructions with hand-computed
// operands/stalls, and short sequences cover latency and mid-flight reset.
module tb_alu_operand_stage;

    import comp16_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [3:0]  in_rd;
    logic [3:0]  in_rs;
    logic [3:0]  in_rt;
    logic [15:0] in_imm;
    logic        in_use_imm;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_op;
    logic [15:0] alu_result;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic [15:0] wb_data;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_imm     (in_imm),
        .in_use_imm (in_use_imm),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    // Behavioural registered ALU: one edge from operands to result.
    function automatic logic [15:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic [3:0] op);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_MUL:  return a * b;
            ALU_NOT:  return ~a;
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            ALU_LNOT: return 16'(a == 16'd0);
            ALU_LAND: return 16'((a != 16'd0) && (b != 16'd0));
            ALU_SHR:  return a >> b[3:0];
            ALU_SHL:  return a << b[3:0];
            ALU_EQ:   return 16'(a == b);
            ALU_GT:   return 16'(a > b);
            ALU_GE:   return 16'(a >= b);
            ALU_LOR:  return 16'((a != 16'd0) || (b != 16'd0));
            ALU_XOR:  return a ^ b;
            default:  return a;
        endcase
    endfunction

    logic [15:0] m_result = 16'd0;
    always @(posedge clk) m_result <= alu_model(alu_a, alu_b, alu_op);
    assign alu_result = m_result;

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic [15:0] imm;
        logic        use_imm;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        int          exp_stalls;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_reg(input string name, input logic [3:0] idx, input logic [15:0] exp);
        dbg_addr = idx;
        #1;
        check($sformatf("%s R%0d", name, idx), 32'(dbg_data), 32'(exp));
    endtask

    task automatic do_reset(input int edges);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        repeat (edges) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Offer one instruction, count cycles with in_ready low, return just
    // after the accepting edge with in_valid dropped.
    task automatic offer(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                         input logic [3:0] rt, input logic [15:0] imm, input logic use_imm,
                         output int stalls);
        in_op      = op;
        in_rd      = rd;
        in_rs      = rs;
        in_rt      = rt;
        in_imm     = imm;
        in_use_imm = use_imm;
        in_valid   = 1'b1;
        stalls     = 0;
        @(negedge clk);
        while (!in_ready && stalls < 8) begin
            stalls++;
            @(negedge clk);
        end
        if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    vec_t        vecs [10];
    logic [15:0] exp_regs [16];
    int          st;

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_op      = '0;
        in_rd      = '0;
        in_rs      = '0;
        in_rt      = '0;
        in_imm     = '0;
        in_use_imm = 1'b0;
        dbg_addr   = '0;

        // Back-to-back program; expected operands/stalls derived by hand.
        vecs[0] = '{ALU_ADD, 4'd1,  4'd0, 4'd0,  16'h0005, 1'b1, 16'h0000, 16'h0005, 0};
        vecs[1] = '{ALU_ADD, 4'd4,  4'd0, 4'd0,  16'h0007, 1'b1, 16'h0000, 16'h0007, 0};
        vecs[2] = '{ALU_SUB, 4'd3,  4'd1, 4'd0,  16'h0002, 1'b1, 16'h0005, 16'h0002, 0};
        vecs[3] = '{ALU_ADD, 4'd2,  4'd1, 4'd1,  16'h0000, 1'b0, 16'h0005, 16'h0005, 0};
        vecs[4] = '{ALU_ADD, 4'd8,  4'd2, 4'd2,  16'h0000, 1'b0, 16'h000A, 16'h000A, 1};
        vecs[5] = '{ALU_ADD, 4'd0,  4'd0, 4'd0,  16'h1234, 1'b1, 16'h0000, 16'h1234, 0};
        vecs[6] = '{ALU_OR,  4'd5,  4'd0, 4'd0,  16'h00F0, 1'b1, 16'h0000, 16'h00F0, 0};
        vecs[7] = '{ALU_XOR, 4'd9,  4'd8, 4'd5,  16'h0000, 1'b0, 16'h0014, 16'h00F0, 1};
        vecs[8] = '{ALU_SUB, 4'd10, 4'd9, 4'd1,  16'h0004, 1'b1, 16'h00E4, 16'h0004, 1};
        vecs[9] = '{ALU_AND, 4'd11, 4'd1, 4'd10, 16'h00FF, 1'b1, 16'h0005, 16'h00FF, 0};

        exp_regs = '{16'h0000, 16'h0005, 16'h000A, 16'h0003, 16'h0007, 16'h00F0, 16'h0000, 16'h0000,
                     16'h0014, 16'h00E4, 16'h00E0, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 16'h0000};

        // Reset state.
        do_reset(2);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset wb_valid", 32'(wb_valid), 32'd0);
        check("reset alu_op",   32'(alu_op),   32'hF);
        check("reset alu_a",    32'(alu_a),    32'd0);
        check("reset alu_b",    32'(alu_b),    32'd0);
        for (int i = 0; i < 16; i++) check_reg("reset", 4'(i), 16'h0000);

        // Latency: accept at N, operands after N, writeback after N+1, file after N+2.
        do_reset(1);
        offer(ALU_ADD, 4'd1, 4'd0, 4'd0, 16'h0005, 1'b1, st);
        check("lat stalls",      32'(st),       32'd0);
        check("lat alu_a",       32'(alu_a),    32'h0000);
        check("lat alu_b",       32'(alu_b),    32'h0005);
        check("lat alu_op",      32'(alu_op),   32'(ALU_ADD));
        check("lat wb_valid N",  32'(wb_valid), 32'd0);
        @(posedge clk); #1;
        check("lat wb_valid N1", 32'(wb_valid), 32'd1);
        check("lat wb_rd",       32'(wb_rd),    32'd1);
        check("lat wb_data",     32'(wb_data),  32'h0005);
        check_reg("lat before write", 4'd1, 16'h0000);
        @(posedge clk); #1;
        check("lat wb_valid N2", 32'(wb_valid), 32'd0);
        check_reg("lat after write", 4'd1, 16'h0005);

        // Table: stalls, forwarding, register 0, immediate ignoring rt.
        do_reset(1);
        for (int v = 0; v < 10; v++) begin
            offer(vecs[v].op, vecs[v].rd, vecs[v].rs, vecs[v].rt, vecs[v].imm, vecs[v].use_imm, st);
            check($sformatf("vec%0d stalls", v), 32'(st),     32'(vecs[v].exp_stalls));
            check($sformatf("vec%0d alu_a", v),  32'(alu_a),  32'(vecs[v].exp_a));
            check($sformatf("vec%0d alu_b", v),  32'(alu_b),  32'(vecs[v].exp_b));
            check($sformatf("vec%0d alu_op", v), 32'(alu_op), 32'(vecs[v].op));
        end
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) check_reg("table", 4'(i), exp_regs[i]);

        // Reset while E1 (R7) and E2 (R6) are both in flight.
        offer(ALU_ADD, 4'd6, 4'd0, 4'd0, 16'h0009, 1'b1, st);
        offer(ALU_ADD, 4'd7, 4'd0, 4'd0, 16'h0003, 1'b1, st);
        check("midrst wb_valid before", 32'(wb_valid), 32'd1);
        check("midrst wb_rd before",    32'(wb_rd),    32'd6);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("midrst wb_valid c%0d", c), 32'(wb_valid), 32'd0);
            @(posedge clk); #1;
        end
        check("midrst in_ready", 32'(in_ready), 32'd1);
        check("midrst alu_op",   32'(alu_op),   32'hF);
        check_reg("midrst", 4'd6, 16'h0000);
        check_reg("midrst", 4'd7, 16'h0000);
        check_reg("midrst", 4'd1, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
